// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: data/address widths, load/store size encodings
// and the data-memory controller state type.
package rv32i_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    // memMode encodings
    localparam logic MEM_MODE_WORD = 1'b0;
    localparam logic MEM_MODE_BYTE = 1'b1;

    // Data-memory controller states
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane helper for the data memory: merges a byte store into the
// addressed word and produces the (sign-extended) load value. Purely
// combinational.
module dmem_lane
    import rv32i_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] old_word_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    input  logic                  mode_i,
    input  logic [1:0]            lane_i,
    output logic [WORD_WIDTH-1:0] merged_o,
    output logic [WORD_WIDTH-1:0] load_o
);

    logic [7:0] load_byte;

    // Word mode passes whole words through; byte mode works on lane lane_i.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves a value unassigned and no latch is inferred.
        load_byte = old_word_i[{lane_i, 3'b000} +: 8];
        merged_o  = wdata_i;
        load_o    = old_word_i;
        if (mode_i == MEM_MODE_BYTE) begin
            merged_o                       = old_word_i;
            merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            load_o                         = {{(WORD_WIDTH-8){load_byte[7]}}, load_byte};
        end
    end

endmodule

// File: rtl/dmem.sv
// Data memory: DEPTH_WORDS x 32-bit words, byte-addressed, word and
// sign-extended byte access, registered read data (1-cycle latency),
// read-before-write on simultaneous read/write, misaligned word accesses
// rejected with a one-cycle flag.
// Optional feature: define DMEM_CLEAR_ON_RESET_EN to zero the whole array
// after every reset (CLEAR state); otherwise contents survive reset and the
// memory is ready immediately.
module dmem
    import rv32i_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic                  memMode,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  misaligned
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam dmem_state_t RESET_STATE = ST_CLEAR;
`else
    localparam dmem_state_t RESET_STATE = ST_READY;
`endif

    dmem_state_t           state_q, state_d;
    logic [WORD_WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic                  misaligned_q, misaligned_d;

`ifdef DMEM_CLEAR_ON_RESET_EN
    logic [IDX_W-1:0]      clr_cnt_q, clr_cnt_d;
`endif

    logic [IDX_W-1:0]      word_idx;
    logic [1:0]            lane;
    logic                  is_byte, aligned, rd_acc, wr_acc;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_widx;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic [WORD_WIDTH-1:0] old_word, merged_word, load_word;
    logic                  unused_addr_bits;

    // Address bits above the array size are ignored, so addresses wrap.
    assign word_idx         = addr[IDX_W+1:2];
    assign lane             = addr[1:0];
    assign unused_addr_bits = ^addr[ADDR_WIDTH-1:IDX_W+2];
    assign old_word         = mem_q[word_idx];

    dmem_lane u_lane (
        .old_word_i (old_word),
        .wdata_i    (wdata),
        .mode_i     (memMode),
        .lane_i     (lane),
        .merged_o   (merged_word),
        .load_o     (load_word)
    );

    // Requests are only honoured in READY and never while reset is asserted.
    assign ready      = (state_q == ST_READY) && !rst;
    assign rdata      = rdata_q;
    assign misaligned = misaligned_q;

    // Next-state logic: walk the clear counter once, then stay in READY.
    always_comb begin
        state_d = state_q;
`ifdef DMEM_CLEAR_ON_RESET_EN
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_CLEAR;
        endcase
`else
        state_d = ST_READY;
`endif
    end

    // Access decode: accept aligned requests, flag misaligned word accesses,
    // and steer the single write port between clearing and stores.
    always_comb begin
        is_byte      = (memMode == MEM_MODE_BYTE);
        aligned      = is_byte || (lane == 2'b00);
        rd_acc       = ready && memRead && aligned;
        wr_acc       = ready && memWrite && aligned;
        misaligned_d = ready && (memRead || memWrite) && !aligned;
        rdata_d      = rd_acc ? load_word : rdata_q;
        mem_we       = wr_acc;
        mem_widx     = word_idx;
        mem_wdata    = merged_word;
`ifdef DMEM_CLEAR_ON_RESET_EN
        if ((state_q == ST_CLEAR) && !rst) begin
            mem_we    = 1'b1;
            mem_widx  = clr_cnt_q;
            mem_wdata = '0;
        end
`endif
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= RESET_STATE;
            rdata_q      <= '0;
            misaligned_q <= 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
            clr_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rdata_q      <= rdata_d;
            misaligned_q <= misaligned_d;
`ifdef DMEM_CLEAR_ON_RESET_EN
            clr_cnt_q    <= clr_cnt_d;
`endif
        end
    end

    // Storage array write port; reads see pre-write contents at this edge.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it maps onto RAM; zeroing, when
        // wanted, is done one word per cycle by the CLEAR state.
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_dmem.sv
// Self-checking bench for dmem (DEPTH_WORDS=16): directed scenarios with
// literal expectations, then randomized traffic compared every cycle against
// a byte-array reference model. Works with or without DMEM_CLEAR_ON_RESET_EN.
module tb_dmem;

    localparam int DEPTH  = 16;
    localparam int NBYTES = DEPTH * 4;
`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam int CLEAR_CYCLES = DEPTH;
`else
    localparam int CLEAR_CYCLES = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic        memMode = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        misaligned;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem #(.DEPTH_WORDS(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .memMode    (memMode),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .misaligned (misaligned)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mb [NBYTES];
    bit          kb [NBYTES];
    int          clear_left = 0;
    bit          started = 0;
    logic [31:0] e_rdata = '0;
    bit          e_rknown = 0;
    bit          e_mis = 0;

    initial for (int i = 0; i < NBYTES; i++) kb[i] = 0;

    always @(posedge clk) begin : model
        int a, w, ln;
        if (rst) begin
            started    = 1;
            clear_left = CLEAR_CYCLES;
            e_rdata    = '0;
            e_rknown   = 1;
            e_mis      = 0;
        end else if (started) begin
            if (clear_left > 0) begin
                e_mis = 0;
                clear_left--;
                if (clear_left == 0)
                    for (int i = 0; i < NBYTES; i++) begin mb[i] = 8'h00; kb[i] = 1; end
            end else begin
                a  = int'(addr % 32'(NBYTES));
                ln = a % 4;
                w  = a - ln;
                e_mis = 0;
                if ((memRead || memWrite) && !memMode && ln != 0) begin
                    e_mis = 1;
                end else begin
                    if (memRead) begin
                        if (memMode) begin
                            e_rdata  = {{24{mb[a][7]}}, mb[a]};
                            e_rknown = kb[a];
                        end else begin
                            e_rdata  = {mb[w+3], mb[w+2], mb[w+1], mb[w]};
                            e_rknown = kb[w] && kb[w+1] && kb[w+2] && kb[w+3];
                        end
                    end
                    if (memWrite) begin
                        if (memMode) begin
                            mb[a] = wdata[7:0];
                            kb[a] = 1;
                        end else begin
                            for (int i = 0; i < 4; i++) begin
                                mb[w+i] = wdata[8*i +: 8];
                                kb[w+i] = 1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("ready", {31'b0, ready}, {31'b0, (!rst && clear_left == 0)});
            check("misaligned", {31'b0, misaligned}, {31'b0, e_mis});
            if (e_rknown) check("rdata", rdata, e_rdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic op(input logic r, input logic rd, input logic wr, input logic md,
                      input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #2;
        rst = r; memRead = rd; memWrite = wr; memMode = md; addr = a; wdata = wd;
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        #1;
        while (ready !== 1'b1 && n < 200) begin
            idle();
            #1;
            n++;
        end
        check(name, n, CLEAR_CYCLES);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        op(1, 0, 0, 0, 0, 0);
        op(1, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0);
        wait_ready("cycles_to_ready");

`ifdef DMEM_CLEAR_ON_RESET_EN
        op(0, 1, 0, 0, 32'h3C, 0); idle();
        check("cleared_word_3c", rdata, 32'h0000_0000);
`endif

        // word store, then byte loads (write then read next cycle)
        op(0, 0, 1, 0, 32'h8, 32'h1122_3344);
        op(0, 1, 0, 1, 32'hB, 0); idle();
        check("byte_read_b", rdata, 32'h0000_0011);
        op(0, 1, 0, 1, 32'h8, 0); idle();
        check("byte_read_8", rdata, 32'h0000_0044);

        // byte store preserves other lanes; negative byte sign-extends
        op(0, 0, 1, 1, 32'h9, 32'h0000_00F0);
        op(0, 1, 0, 1, 32'h9, 0); idle();
        check("byte_read_9_sext", rdata, 32'hFFFF_FFF0);
        op(0, 1, 0, 0, 32'h8, 0); idle();
        check("word_read_8_merged", rdata, 32'h1122_F044);

        // misaligned word write is rejected and flagged for one cycle
        op(0, 0, 1, 0, 32'h4, 32'hCAFE_BABE);
        op(0, 1, 0, 0, 32'h8, 0); idle();
        op(0, 0, 1, 0, 32'h6, 32'hDEAD_BEEF); idle();
        check("misaligned_pulse", {31'b0, misaligned}, 32'h1);
        check("misaligned_rdata_hold", rdata, 32'h1122_F044);
        idle();
        check("misaligned_one_cycle", {31'b0, misaligned}, 32'h0);
        op(0, 1, 0, 0, 32'h4, 0); idle();
        check("word_4_untouched", rdata, 32'hCAFE_BABE);

        // simultaneous read and write: read returns old contents
        op(0, 0, 1, 0, 32'h10, 32'hAAAA_5555);
        op(0, 1, 1, 0, 32'h10, 32'h1234_5678); idle();
        check("rbw_old_data", rdata, 32'hAAAA_5555);
        op(0, 1, 0, 0, 32'h10, 0); idle();
        check("rbw_new_data", rdata, 32'h1234_5678);

        // reset in READY discards in-flight read data
        op(0, 1, 0, 0, 32'h10, 0);
        op(1, 0, 0, 0, 0, 0);
        check("read_before_reset", rdata, 32'h1234_5678);
        op(0, 0, 0, 0, 0, 0);
        check("rdata_zero_after_reset", rdata, 32'h0000_0000);

        // reset pulsed while clearing index 7 restarts the clear
        repeat (6) idle();
        op(1, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0);
        wait_ready("cycles_to_ready_restart");

        // wrap-around: 0x40 aliases word 0 for 16 words
        op(0, 0, 1, 0, 32'h0, 32'h5A5A_0001);
        op(0, 1, 0, 0, 32'h40, 0); idle();
        check("wrap_read_40", rdata, 32'h5A5A_0001);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            logic        r, rd, wr, md;
            logic [31:0] a;
            r  = ($urandom_range(0, 299) == 0);
            rd = $urandom_range(0, 1) == 1;
            wr = $urandom_range(0, 9) < 4;
            md = $urandom_range(0, 1) == 1;
            a  = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, NBYTES - 1));
            op(r, rd, wr, md, a, $urandom());
        end

        repeat (3) idle();
        @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem.md
DMEM -- requirements
Module: dmem

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; SHALL be a power of two, minimum 4.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-004 memRead  input  1  read request for the current cycle.
REQ-005 memWrite  input  1  write request for the current cycle.
REQ-006 memMode  input  1  access size: 0 = word, 1 = byte.
REQ-007 addr  input  ADDR_WIDTH  byte address.
REQ-008 wdata  input  WORD_WIDTH  store data; byte stores use wdata[7:0].
REQ-009 rdata  output  WORD_WIDTH  registered load data.
REQ-010 ready  output  1  1 = requests are accepted; 0 = memory is initialising.
REQ-011 misaligned  output  1  one-cycle pulse flagging a rejected misaligned word access.

Function
REQ-012 FSM states: CLEAR and READY. CLEAR SHALL write zero to word index clrCnt each cycle, then increment clrCnt. The CLEAR -> READY transition SHALL occur in the cycle after clrCnt = DEPTH_WORDS-1 is written.
REQ-013 ready SHALL be 1 only in READY. In CLEAR, memRead and memWrite SHALL be ignored, rdata SHALL hold, and misaligned SHALL stay 0.
REQ-014 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]. Higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-015 Read latency SHALL be exactly 1 cycle: a read accepted in cycle N SHALL present its data on rdata in cycle N+1. rdata SHALL hold that value until the next accepted read.
REQ-016 Word read SHALL return the full word. Byte read SHALL return lane addr[1:0] (little-endian, lane 0 = bits 7:0), sign-extended to 32 bits.
REQ-017 Word write SHALL replace the whole word. Byte write SHALL update only lane addr[1:0]; the other three lanes SHALL be preserved.
REQ-018 A word access with addr[1:0] != 0 SHALL NOT modify memory or rdata, and SHALL pulse misaligned=1 in cycle N+1. Byte accesses are never misaligned.
REQ-019 If memRead and memWrite are asserted in the same cycle, the write SHALL be performed and the read SHALL return the pre-write contents (read-before-write).
REQ-020 A write in cycle N followed by a read of the same address in cycle N+1 SHALL return the newly written data.

Reset
REQ-021 When rst=1: the FSM SHALL enter CLEAR (or READY when the clear feature is compiled out), clrCnt=0, rdata=0, misaligned=0, ready=0.
REQ-022 Reset asserted mid-CLEAR SHALL restart the clear from index 0. Reset asserted in READY SHALL discard any in-flight read, and rdata SHALL read 0 on the following cycle.

Configuration
REQ-023 Macro DMEM_CLEAR_ON_RESET_EN defined: the CLEAR state and clrCnt SHALL exist as in REQ-012.
REQ-024 Macro DMEM_CLEAR_ON_RESET_EN undefined: no CLEAR state or counter. ready SHALL be 1 in the first cycle after rst deasserts, and memory contents SHALL be preserved across reset.

Structure
REQ-025 WORD_WIDTH, ADDR_WIDTH, the memMode encodings (MEM_MODE_WORD=0, MEM_MODE_BYTE=1) and the dmem_state_t enum SHALL live in the shared rv32i definitions package.
REQ-026 Byte-lane write merging and load sign-extension SHALL be factored into one combinational sub-module, dmem_lane.

Verification
REQ-027 Reset, then count cycles until ready=1 (DEPTH_WORDS=16): ready rises after exactly 16 CLEAR cycles, and a word read of addr 0x3C returns 0x00000000.
REQ-028 Word write 0x11223344 to 0x8, then a byte read of 0xB: the next cycle gives rdata=0x00000011. A byte read of 0x8 gives 0x00000044.
REQ-029 Byte write 0xF0 to 0x9 over word 0x11223344, then a byte read of 0x9: rdata=0xFFFFFFF0. A word read of 0x8 gives 0x1122F044.
REQ-030 Word write to 0x6: misaligned=1 for one cycle, no memory change (a word read of 0x4 returns its prior value), and rdata unchanged.
REQ-031 Same-cycle read and write of 0x10 (old 0xAAAA5555, new 0x12345678): rdata=0xAAAA5555, and the following read returns 0x12345678.
REQ-032 rst pulsed at clear index 7, and a read of address 0x40 (DEPTH_WORDS=16) after a write to 0x0: clear restarts at 0 and ready is delayed 16 cycles; the read returns word 0 (wrap-around).
